// File: rtl/global_ldst_ar_sched.sv
// AXI AR-channel scheduler: splits a byte-range global read into INCR bursts of at most 256 beats.
// Define GLOBAL_LDST_PAGE_SPLIT_EN so that no burst crosses a 4 KiB boundary.
module global_ldst_ar_sched #(
  parameter int unsigned AxiDataWidth   = 128,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AxiAddrWidth-1:0] req_addr_i,
  input  logic [31:0]             req_bytes_i,
  input  logic [AxiIdWidth-1:0]   req_id_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [AxiAddrWidth-1:0] ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [AxiIdWidth-1:0]   ar_id_o,
  input  logic                    r_valid_i,
  input  logic                    r_ready_i,
  input  logic                    r_last_i,
  output logic                    busy_o
);

  localparam int unsigned Bytes      = AxiDataWidth / 8;
  localparam int unsigned SizeAxi    = $clog2(Bytes);
  localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeatsWidth = 33;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                  state_q, state_d;
  logic [AxiAddrWidth-1:0] cur_addr_q, cur_addr_d;
  logic [BeatsWidth-1:0]   beats_left_q, beats_left_d;
  logic [AxiIdWidth-1:0]   id_q, id_d;
  logic [CntWidth-1:0]     outstanding_q, outstanding_d;

  logic [AxiAddrWidth-1:0] req_end_addr;
  logic [AxiAddrWidth-1:0] req_beats;
  logic [8:0]              burst_beats;
  logic                    ar_fire;
  logic                    r_fire;

  // Beat count spans every beat touched by the unaligned byte range.
  assign req_end_addr = req_addr_i + AxiAddrWidth'(req_bytes_i) - AxiAddrWidth'(1);
  assign req_beats    = (req_end_addr >> SizeAxi) - (req_addr_i >> SizeAxi) + AxiAddrWidth'(1);

`ifdef GLOBAL_LDST_PAGE_SPLIT_EN
  logic [12:0] page_beats;
  assign page_beats = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> SizeAxi;
`endif

  always_comb begin
    burst_beats = 9'd256;
    if (beats_left_q < BeatsWidth'(256)) begin
      burst_beats = beats_left_q[8:0];
    end
`ifdef GLOBAL_LDST_PAGE_SPLIT_EN
    if (page_beats < {4'b0, burst_beats}) begin
      burst_beats = page_beats[8:0];
    end
`endif
  end

  assign ar_fire = ar_valid_o & ar_ready_i;
  // An R last with nothing outstanding is stray and must not underflow the counter.
  assign r_fire  = r_valid_i & r_ready_i & r_last_i & (outstanding_q != '0);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cur_addr_q    <= '0;
      beats_left_q  <= '0;
      id_q          <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      beats_left_q  <= beats_left_d;
      id_q          <= id_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    id_d         = id_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i && (req_bytes_i != '0)) begin
          cur_addr_d   = req_addr_i & ~AxiAddrWidth'(Bytes - 1);
          beats_left_d = BeatsWidth'(req_beats);
          id_d         = req_id_i;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (ar_fire) begin
          cur_addr_d   = cur_addr_q + (AxiAddrWidth'(burst_beats) << SizeAxi);
          beats_left_d = beats_left_q - BeatsWidth'(burst_beats);
          if (beats_left_d == '0) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (ar_fire && !r_fire) begin
      outstanding_d = outstanding_q + CntWidth'(1);
    end else if (r_fire && !ar_fire) begin
      outstanding_d = outstanding_q - CntWidth'(1);
    end
  end

  // Outputs; AR payload only moves on a handshake, so it is stable while valid waits.
  always_comb begin
    req_ready_o = (state_q == StIdle);
    ar_valid_o  = (state_q == StIssue) && (outstanding_q < CntWidth'(MaxOutstanding));
    ar_addr_o   = cur_addr_q;
    ar_len_o    = burst_beats[7:0] - 8'd1;
    ar_size_o   = 3'(SizeAxi);
    ar_id_o     = id_q;
    busy_o      = (state_q != StIdle) || (outstanding_q != '0);
  end

endmodule

// File: tb/tb_global_ldst_ar_sched.sv
// Directed bench for global_ldst_ar_sched: vector table plus stall, outstanding-limit and reset cases.
module tb_global_ldst_ar_sched;

  localparam int unsigned MaxOut = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [31:0] req_bytes;
  logic [3:0]  req_id;
  logic        ar_valid, ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [3:0]  ar_id;
  logic        r_valid, r_ready, r_last;
  logic        busy;

  always #5 clk = ~clk;

  global_ldst_ar_sched #(
    .AxiDataWidth  (128),
    .AxiAddrWidth  (64),
    .AxiIdWidth    (4),
    .MaxOutstanding(MaxOut)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_bytes_i(req_bytes),
    .req_id_i   (req_id),
    .ar_valid_o (ar_valid),
    .ar_ready_i (ar_ready),
    .ar_addr_o  (ar_addr),
    .ar_len_o   (ar_len),
    .ar_size_o  (ar_size),
    .ar_id_o    (ar_id),
    .r_valid_i  (r_valid),
    .r_ready_i  (r_ready),
    .r_last_i   (r_last),
    .busy_o     (busy)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] bytes;
    logic [3:0]  id;
    logic [1:0]  n;
    logic [63:0] a0;
    logic [7:0]  l0;
    logic [63:0] a1;
    logic [7:0]  l1;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_req(input logic [63:0] a, input logic [31:0] b, input logic [3:0] id);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_bytes = b;
    req_id    = id;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    chk($sformatf("v%0d req_ready", idx), 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_bytes = v.bytes;
    req_id    = v.id;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < int'(v.n); k++) begin
      chk($sformatf("v%0d b%0d ar_valid", idx, k), 64'(ar_valid), 64'd1);
      chk($sformatf("v%0d b%0d ar_addr", idx, k), ar_addr, (k == 0) ? v.a0 : v.a1);
      chk($sformatf("v%0d b%0d ar_len", idx, k), 64'(ar_len), 64'((k == 0) ? v.l0 : v.l1));
      chk($sformatf("v%0d b%0d ar_size", idx, k), 64'(ar_size), 64'd4);
      chk($sformatf("v%0d b%0d ar_id", idx, k), 64'(ar_id), 64'(v.id));
      @(negedge clk);
    end
    chk($sformatf("v%0d done ar_valid", idx), 64'(ar_valid), 64'd0);
    chk($sformatf("v%0d done req_ready", idx), 64'(req_ready), 64'd1);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{addr: 64'h1000, bytes: 32'd64, id: 4'h1, n: 2'd1,
                a0: 64'h1000, l0: 8'd3, a1: 64'h0, l1: 8'd0};
`ifdef GLOBAL_LDST_PAGE_SPLIT_EN
    vecs[1] = '{addr: 64'h1FF8, bytes: 32'd32, id: 4'h2, n: 2'd2,
                a0: 64'h1FF0, l0: 8'd0, a1: 64'h2000, l1: 8'd1};
    vecs[5] = '{addr: 64'h0FF0, bytes: 32'd4112, id: 4'h6, n: 2'd2,
                a0: 64'h0FF0, l0: 8'd0, a1: 64'h1000, l1: 8'd255};
`else
    vecs[1] = '{addr: 64'h1FF8, bytes: 32'd32, id: 4'h2, n: 2'd1,
                a0: 64'h1FF0, l0: 8'd2, a1: 64'h0, l1: 8'd0};
    vecs[5] = '{addr: 64'h0FF0, bytes: 32'd4112, id: 4'h6, n: 2'd2,
                a0: 64'h0FF0, l0: 8'd255, a1: 64'h1FF0, l1: 8'd0};
`endif
    vecs[2] = '{addr: 64'h0, bytes: 32'd8192, id: 4'h3, n: 2'd2,
                a0: 64'h0, l0: 8'd255, a1: 64'h1000, l1: 8'd255};
    vecs[3] = '{addr: 64'h23, bytes: 32'd1, id: 4'h4, n: 2'd1,
                a0: 64'h20, l0: 8'd0, a1: 64'h0, l1: 8'd0};
    vecs[4] = '{addr: 64'h0F, bytes: 32'd2, id: 4'h5, n: 2'd1,
                a0: 64'h0, l0: 8'd1, a1: 64'h0, l1: 8'd0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_bytes = '0;
    req_id    = '0;
    ar_ready  = 1'b1;
    r_valid   = 1'b0;
    r_ready   = 1'b0;
    r_last    = 1'b0;

    @(negedge clk);
    chk("reset ar_valid", 64'(ar_valid), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // R lasts return continuously so the table never hits the outstanding limit.
    r_valid = 1'b1;
    r_ready = 1'b1;
    r_last  = 1'b1;
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    @(negedge clk);
    @(negedge clk);
    r_valid = 1'b0;
    r_ready = 1'b0;
    r_last  = 1'b0;
    chk("table drained busy", 64'(busy), 64'd0);

    // Zero-byte request: accepted, no burst, never busy.
    send_req(64'h40, 32'd0, 4'h7);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("zero c%0d ar_valid", i), 64'(ar_valid), 64'd0);
      chk($sformatf("zero c%0d req_ready", i), 64'(req_ready), 64'd1);
      chk($sformatf("zero c%0d busy", i), 64'(busy), 64'd0);
      @(negedge clk);
    end

    // AR back-pressure: valid and payload hold until ready.
    ar_ready = 1'b0;
    send_req(64'h1000, 32'd64, 4'h5);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall c%0d ar_valid", i), 64'(ar_valid), 64'd1);
      chk($sformatf("stall c%0d ar_addr", i), ar_addr, 64'h1000);
      chk($sformatf("stall c%0d ar_len", i), 64'(ar_len), 64'd3);
      if (i < 2) @(negedge clk);
    end
    ar_ready = 1'b1;
    @(negedge clk);
    chk("stall after ar_valid", 64'(ar_valid), 64'd0);
    chk("stall after busy", 64'(busy), 64'd1);
    r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
    @(negedge clk);
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    chk("stall drained busy", 64'(busy), 64'd0);

    // Outstanding limit: 3 bursts, only MaxOut issue until an R last returns.
    send_req(64'h0, 32'd12288, 4'h9);
    chk("lim ar0 valid", 64'(ar_valid), 64'd1);
    chk("lim ar0 addr", ar_addr, 64'h0);
    @(negedge clk);
    chk("lim ar1 valid", 64'(ar_valid), 64'd1);
    chk("lim ar1 addr", ar_addr, 64'h1000);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lim hold c%0d ar_valid", i), 64'(ar_valid), 64'd0);
      chk($sformatf("lim hold c%0d busy", i), 64'(busy), 64'd1);
      @(negedge clk);
    end
    r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
    @(negedge clk);
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    chk("lim ar2 valid", 64'(ar_valid), 64'd1);
    chk("lim ar2 addr", ar_addr, 64'h2000);
    chk("lim ar2 len", 64'(ar_len), 64'd255);
    @(negedge clk);
    chk("lim end ar_valid", 64'(ar_valid), 64'd0);
    chk("lim end req_ready", 64'(req_ready), 64'd1);
    chk("lim end busy", 64'(busy), 64'd1);
    r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
    @(negedge clk);
    chk("lim one left busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("lim drained busy", 64'(busy), 64'd0);
    // A further stray R last must not underflow the counter.
    @(negedge clk);
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    chk("stray r_last busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("stray r_last busy later", 64'(busy), 64'd0);

    // Reset while an AR is pending abandons the request.
    ar_ready = 1'b0;
    send_req(64'h0, 32'd8192, 4'h3);
    chk("rst pre ar_valid", 64'(ar_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst ar_valid", 64'(ar_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    ar_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post rst c%0d ar_valid", i), 64'(ar_valid), 64'd0);
      chk($sformatf("post rst c%0d busy", i), 64'(busy), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
